// File: rtl/alu_seq_acc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_seq_acc                                                  |
// | Description : Registered ALU with 2W-bit result/accumulator register,      |
// |               start/ready/done handshake and a multi-cycle unsigned        |
// |               shift-add multiply. Optional seven-segment decode of the     |
// |               result when ALU_SEQ_HEX_EN is defined (adds hex_out).        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_seq_acc #(
  parameter int W = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             use_acc,
  output logic             ready,
  output logic             done,
  output logic [2*W-1:0]   result
`ifdef ALU_SEQ_HEX_EN
  ,
  output logic [7*(W/2)-1:0] hex_out
`endif
);

  localparam int RW = 2 * W;
  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] C_CNT_LAST = CW'(W - 1);

  localparam logic [2:0] C_OP_INC  = 3'd0;
  localparam logic [2:0] C_OP_ADD  = 3'd1;
  localparam logic [2:0] C_OP_ADD2 = 3'd2;
  localparam logic [2:0] C_OP_BITS = 3'd3;
  localparam logic [2:0] C_OP_ANY  = 3'd4;
  localparam logic [2:0] C_OP_CAT  = 3'd5;
  localparam logic [2:0] C_OP_MUL  = 3'd6;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   result_q, result_d;
  logic            done_q, done_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [RW-1:0]   pp_q, pp_d;

  logic            w_accept;
  logic [W-1:0]    w_b_sel;
  logic [RW-1:0]   w_a_ext;
  logic [RW-1:0]   w_b_ext;
  logic [RW-1:0]   w_alu;
  logic [RW-1:0]   w_addend;

  assign ready    = (state_q == S_IDLE);
  assign done     = done_q;
  assign result   = result_q;

  assign w_accept = ready && start;
  // Accumulate mode feeds the low half of the current result back as B.
  assign w_b_sel  = use_acc ? result_q[W-1:0] : b;
  assign w_a_ext  = {{W{1'b0}}, a};
  assign w_b_ext  = {{W{1'b0}}, w_b_sel};
  // Shifted multiplicand for the current multiplier bit (zero if bit clear).
  assign w_addend = b_q[cnt_q] ? ({{W{1'b0}}, a_q} << cnt_q) : '0;

  // Single-cycle operation results; sums fit in 2W bits so no wrap occurs.
  always_comb begin
    w_alu = result_q;
    case (op)
      C_OP_INC:             w_alu = w_a_ext + RW'(1);
      C_OP_ADD, C_OP_ADD2:  w_alu = w_a_ext + w_b_ext;
      C_OP_BITS:            w_alu = {a | w_b_sel, a ^ w_b_sel};
      C_OP_ANY:             w_alu = {{(RW-1){1'b0}}, |{a, w_b_sel}};
      C_OP_CAT:             w_alu = {a, w_b_sel};
      default:              w_alu = result_q;
    endcase
  end

  // Next-state logic: accept in IDLE, one multiplier bit per cycle in MUL.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    pp_d     = pp_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          if (op == C_OP_MUL) begin
            // Operands are captured so later result writes cannot disturb them.
            state_d = S_MUL;
            a_d     = a;
            b_d     = w_b_sel;
            pp_d    = '0;
            cnt_d   = '0;
          end else begin
            result_d = w_alu;
            done_d   = 1'b1;
          end
        end
      end
      S_MUL: begin
        pp_d  = pp_q + w_addend;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == C_CNT_LAST) begin
          state_d  = S_IDLE;
          result_d = pp_q + w_addend;
          done_d   = 1'b1;
          cnt_d    = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any multiply in flight.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      pp_q     <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      pp_q     <= pp_d;
    end
  end

`ifdef ALU_SEQ_HEX_EN
  // Active-low 0-F font, segment a..g at bit 0..6.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  for (genvar k = 0; k < W / 2; k++) begin : g_hex
    assign hex_out[7*k +: 7] = seg7(result_q[4*k +: 4]);
  end
`endif

endmodule
`default_nettype wire
